// File: rtl/odd_parity_gen_if.sv
// Bundle for the odd-parity generator: word, qualifiers and
// parity/check results.
interface odd_parity_gen_if #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 16
);
   logic [DATA_W-1:0] data;
   logic              in_valid;
   logic              chk_en;
   logic              rx_par;
   logic              clr_cnt;
   logic              odd_p;
   logic              odd_p_q;
   logic              out_valid;
   logic              par_err;
   logic [CNT_W-1:0]  err_cnt;

   modport master (
      output data, in_valid, chk_en, rx_par, clr_cnt,
      input  odd_p, odd_p_q, out_valid, par_err, err_cnt
   );

   modport slave (
      input  data, in_valid, chk_en, rx_par, clr_cnt,
      output odd_p, odd_p_q, out_valid, par_err, err_cnt
   );
endinterface

// File: rtl/odd_parity_gen.sv
// Odd-parity generator with registered, valid-qualified result
// and receive-side check feeding a saturating error counter.
module odd_parity_gen #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             rst,
   odd_parity_gen_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             odd_p;
   logic             mismatch;
   logic             accept_err;
   logic             odd_p_q;
   logic             out_valid;
   logic             par_err;
   logic [CNT_W-1:0] err_cnt;

   // XNOR-reduce: word plus parity bit always holds an odd number of ones
   assign odd_p      = ~^bus.data;
   assign mismatch   = bus.chk_en & (bus.rx_par != odd_p);
   assign accept_err = bus.in_valid & mismatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         odd_p_q   <= 1'b0;
         out_valid <= 1'b0;
         par_err   <= 1'b0;
      end else begin
         out_valid <= bus.in_valid;
         par_err   <= accept_err;
         if (bus.in_valid) odd_p_q <= odd_p;
      end
   end

   // Clear wins over a simultaneous error; count sticks at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (bus.clr_cnt) begin
         err_cnt <= '0;
      end else if (accept_err && err_cnt != CNT_MAX) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end

   assign bus.odd_p     = odd_p;
   assign bus.odd_p_q   = odd_p_q;
   assign bus.out_valid = out_valid;
   assign bus.par_err   = par_err;
   assign bus.err_cnt   = err_cnt;
endmodule

// File: tb/tb_odd_parity_gen.sv
// Directed bench for odd_parity_gen: expected responses queued by
// the stimulus, popped and compared by a forked monitor.
module tb_odd_parity_gen;
   localparam int DATA_W = 3;
   localparam int CNT_W  = 2;

   typedef struct packed {
      logic             q;
      logic             v;
      logic             e;
      logic [CNT_W-1:0] c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   odd_parity_gen_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   odd_parity_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue the registered result
   task automatic step(input logic [DATA_W-1:0] d, input logic v,
                       input logic ce, input logic rp, input logic clr,
                       input logic eq, input logic ev, input logic ee,
                       input logic [CNT_W-1:0] ec);
      exp_t x;
      bus.data     = d;
      bus.in_valid = v;
      bus.chk_en   = ce;
      bus.rx_par   = rp;
      bus.clr_cnt  = clr;
      @(posedge clk);
      x.q = eq;
      x.v = ev;
      x.e = ee;
      x.c = ec;
      exp_q.push_back(x);
      #1;
   endtask

   logic [7:0] sweep_exp;

   initial begin
      bus.data     = '0;
      bus.in_valid = 1'b0;
      bus.chk_en   = 1'b0;
      bus.rx_par   = 1'b0;
      bus.clr_cnt  = 1'b0;
      sweep_exp    = 8'b0110_1001;

      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (bus.odd_p_q !== e.q || bus.out_valid !== e.v ||
                   bus.par_err !== e.e || bus.err_cnt !== e.c) begin
                  errors++;
                  $display("FAIL regs: got q=%b v=%b e=%b c=%0d expected q=%b v=%b e=%b c=%0d at %0t",
                           bus.odd_p_q, bus.out_valid, bus.par_err, bus.err_cnt,
                           e.q, e.v, e.e, e.c, $time);
               end
            end else if (bus.out_valid !== 1'b0) begin
               checks++;
               errors++;
               $display("FAIL unexpected out_valid: got %b expected 0 at %0t",
                        bus.out_valid, $time);
            end
         end
      join_none

      #2;
      chk("reset odd_p_q", int'(bus.odd_p_q), 0);
      chk("reset out_valid", int'(bus.out_valid), 0);
      chk("reset par_err", int'(bus.par_err), 0);
      chk("reset err_cnt", int'(bus.err_cnt), 0);

      // Combinational sweep, also shows odd_p is live during reset
      for (int i = 0; i < 8; i++) begin
         bus.data = DATA_W'(i);
         #1;
         chk($sformatf("odd_p data=%0d", i), int'(bus.odd_p), int'(sweep_exp[i]));
         #9;
      end
      #1;
      rst = 1'b0;

      // Registered path: 3, 4, idle
      step(3'd3, 1, 0, 0, 0,  1, 1, 0, 2'd0);
      step(3'd4, 1, 0, 0, 0,  0, 1, 0, 2'd0);
      step(3'd0, 0, 0, 0, 0,  0, 0, 0, 2'd0);
      // Check mode: mismatch, then match, then generate-only with bad rx_par
      step(3'd5, 1, 1, 0, 0,  1, 1, 1, 2'd1);
      step(3'd5, 1, 1, 1, 0,  1, 1, 0, 2'd1);
      step(3'd5, 1, 0, 0, 0,  1, 1, 0, 2'd1);
      // Idle mismatch is not an acceptance; clear while idle
      step(3'd7, 0, 1, 1, 1,  1, 0, 0, 2'd0);
      // Saturation: five mismatching words
      step(3'd7, 1, 1, 1, 0,  0, 1, 1, 2'd1);
      step(3'd7, 1, 1, 1, 0,  0, 1, 1, 2'd2);
      step(3'd7, 1, 1, 1, 0,  0, 1, 1, 2'd3);
      step(3'd7, 1, 1, 1, 0,  0, 1, 1, 2'd3);
      step(3'd7, 1, 1, 1, 0,  0, 1, 1, 2'd3);
      // Clear beats a simultaneous error
      step(3'd7, 1, 1, 1, 1,  0, 1, 1, 2'd0);
      // Build up err_cnt=2 with out_valid=1
      step(3'd6, 1, 1, 0, 0,  1, 1, 1, 2'd1);
      step(3'd6, 1, 1, 0, 0,  1, 1, 1, 2'd2);

      // Mid-stream reset between edges, after the monitor has sampled
      #5;
      rst = 1'b1;
      #1;
      chk("midrst odd_p_q", int'(bus.odd_p_q), 0);
      chk("midrst out_valid", int'(bus.out_valid), 0);
      chk("midrst par_err", int'(bus.par_err), 0);
      chk("midrst err_cnt", int'(bus.err_cnt), 0);
      bus.in_valid = 1'b0;
      bus.data = 3'd1;
      #1;
      chk("midrst odd_p data=1", int'(bus.odd_p), 0);
      bus.data = 3'd3;
      #1;
      chk("midrst odd_p data=3", int'(bus.odd_p), 1);
      @(posedge clk);
      #1;
      chk("held in reset out_valid", int'(bus.out_valid), 0);
      #3;
      rst = 1'b0;

      // First acceptance after reset
      step(3'd0, 1, 0, 0, 0,  1, 1, 0, 2'd0);
      step(3'd0, 0, 0, 0, 0,  1, 0, 0, 2'd0);

      @(posedge clk);
      @(posedge clk);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/odd_parity_gen.md
# odd_parity_gen

Odd-parity generator/checker for narrow data words. It produces a combinational odd-parity bit for the current input word. It also provides a registered, valid-qualified parity output plus an optional receive-side check with a saturating error counter. It sits at the edge of a serial/byte link: the transmit side appends `odd_p`, and the receive side checks incoming words against their transmitted parity bit.

## Interface
- `DATA_W`, default 3: width of the data word; legal range 1..64.
- `CNT_W`, default 16: width of the error counter.

- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `data`, input, DATA_W: word to generate or check parity for.
- `in_valid`, input, 1: `data` (and `rx_par`) is valid this cycle.
- `chk_en`, input, 1: 1 selects check mode (compare against `rx_par`); 0 selects generate-only mode.
- `rx_par`, input, 1: received parity bit accompanying `data`, used only when `chk_en`=1.
- `clr_cnt`, input, 1: synchronous clear of `err_cnt`.
- `odd_p`, output, 1: combinational odd-parity bit of `data`.
- `odd_p_q`, output, 1: registered `odd_p` of the last accepted word.
- `out_valid`, output, 1: `odd_p_q` and `par_err` are valid.
- `par_err`, output, 1: registered parity mismatch flag for the last accepted word.
- `err_cnt`, output, CNT_W: saturating count of parity errors.

## Operation
- `odd_p` = XNOR-reduce of `data`, so that `data` plus `odd_p` always contains an odd number of ones.
  - `odd_p`=1 when the popcount of `data` is even, including 0.
  - `odd_p` is independent of `clk`, `rst`, `in_valid` and `chk_en`.
- A word is accepted on a rising edge with `in_valid`=1. On acceptance:
  - `odd_p_q` <= `odd_p`.
  - `out_valid` <= 1.
  - `par_err` <= `chk_en & (rx_par != odd_p)`.
- On a rising edge with `in_valid`=0:
  - `out_valid` <= 0.
  - `par_err` <= 0.
  - `odd_p_q` holds its previous value.
- `err_cnt` update, by priority:
  - `clr_cnt`=1: `err_cnt` <= 0. The clear wins over a simultaneous error.
  - Otherwise, an accepted word with a mismatch in check mode increments `err_cnt` by 1.
  - `err_cnt` saturates at all-ones (2^CNT_W - 1) and never wraps.
- In generate-only mode (`chk_en`=0), `rx_par` is ignored and `par_err` is always 0.

## Timing
- `odd_p`: zero latency, purely combinational from `data`.
- `odd_p_q`, `out_valid`, `par_err`: 1-cycle latency from the accepting edge.
- `err_cnt`: reflects an error 1 cycle after the accepting edge, in the same cycle `par_err` is 1.
- Back-to-back `in_valid` every cycle is supported. There is no backpressure and no ready signal.
- Reset values, applied asynchronously on `rst` assertion regardless of `clk`:
  - `odd_p_q`=0
  - `out_valid`=0
  - `par_err`=0
  - `err_cnt`=0
- Reset asserted mid-stream immediately drops `out_valid` and `par_err`, and discards any in-flight word.
- The first acceptance is at the first rising edge after `rst` deasserts with `in_valid`=1.
- `odd_p` stays live during reset.

## Test plan
- Combinational sweep, DATA_W=3, one word per 10 ns: `data` 0..7 -> `odd_p` = 1,0,0,1,0,1,1,0 respectively.
- Registered path: drive `in_valid`=1 with `data`=3, then 4, then `in_valid`=0 for one cycle.
  - Following cycles: `odd_p_q` = 1, then 0, then holds 0.
  - `out_valid` = 1, 1, 0.
- Check mode, `chk_en`=1:
  - `data`=5 with `rx_par`=0 -> `par_err`=1 next cycle and `err_cnt` goes 0->1.
  - `data`=5 with `rx_par`=1 -> `par_err`=0 and `err_cnt` is unchanged.
- Saturation, CNT_W=2: five consecutive mismatching words -> `err_cnt` reads 1,2,3,3,3.
- Clear priority: a mismatching word with `clr_cnt`=1 in the same cycle -> `err_cnt`=0 next cycle, while `par_err`=1.
- Reset mid-stream: assert `rst` between clock edges while `out_valid`=1 and `err_cnt`=2.
  - All registered outputs go to 0 immediately, without waiting for an edge.
  - `odd_p` continues to track `data`.
